tcp_rx_payload_buffer: RTL
==========================

Name: tcp_rx_payload_buffer

Overview:
- Byte-wide frame buffer directly downstream of the Ethernet TCP/IP receive parser in the webcamera path.
- Captures parser payload bytes into a circular RAM as tentative frame content.
- Commits the frame on the parser's frame-done pulse, or rolls it back on a silent abort.
- Presents committed frames on a valid/ready byte stream with a last marker for the next consumer.

Parameters:
- ADDR_W, 11, payload RAM address width; depth is 2^ADDR_W bytes.
- LQ_AW, 3, length-queue address width; up to 2^LQ_AW committed frames.
- TIMEOUT, 64, idle cycles with uncommitted bytes before rollback.

Ports:
- clk  in  1  receive clock; all logic on posedge.
- clr  in  1  asynchronous active-low reset.
- din  in  8  payload byte from parser.
- din_valid  in  1  din is valid this cycle.
- frame_done  in  1  one-cycle pulse: parser finished a frame.
- frame_len  in  16  parser-reported payload length; stable when frame_done is high.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data valid.
- out_last  out  1  out_data is the final byte of its frame.
- out_ready  in  1  consumer accepts the byte.
- frame_avail  out  1  at least one committed frame is queued or being sent.
- drop_cnt  out  8  saturating count of dropped frames.

Behaviour:
- Reset values:
  - out_data=0, out_valid=0, out_last=0, frame_avail=0, drop_cnt=0.
  - All pointers and counters are 0; buffered content is discarded.
  - Reset mid-frame or mid-read aborts everything immediately.
- Write side pointers: wr_ptr (tentative), cm_ptr (committed start of the next frame), rd_ptr. All are ADDR_W bits and wrap modulo depth.
- Writing a byte:
  - On din_valid: if (wr_ptr+1)==rd_ptr (modulo), the byte is not written and the ovf flag is set for the current frame.
  - Otherwise din is written to RAM[wr_ptr], wr_ptr increments, and wcnt (16-bit) increments.
- Committing a frame (frame_done high):
  - If din_valid is high in the same cycle, that byte belongs to the frame and is counted first.
  - Drop the frame when wcnt (including a same-cycle byte) is 0, when ovf is set, or when the length queue is full.
  - A dropped frame sets wr_ptr=cm_ptr and, except for the zero-length case, increments drop_cnt (saturates at 255).
  - Otherwise push wcnt into the length queue and set cm_ptr=wr_ptr.
  - In every case, clear wcnt, ovf and the idle timer.
- Rollback:
  - The idle timer counts cycles with wcnt!=0, no din_valid and no frame_done.
  - When it reaches TIMEOUT, set wr_ptr=cm_ptr, clear wcnt/ovf, and increment drop_cnt.
  - Any din_valid clears the timer.
- Read FSM:
  - R_IDLE: if the length queue is not empty, pop it into rlen and go to R_FETCH.
  - R_FETCH: issue a registered RAM read at rd_ptr, then go to R_SEND. out_valid goes high the next cycle.
  - R_SEND: hold out_data/out_last while out_valid && !out_ready.
    - On transfer, rd_ptr++ and rlen--.
    - If the transferred byte was last, out_valid=0 and go to R_IDLE.
    - Otherwise prefetch the next byte so back-to-back transfers run at 1 byte/cycle with no bubble.
  - out_last = (rlen==1) while out_valid.
- Latency:
  - frame_done in cycle N gives frame_avail=1 in N+1.
  - First out_valid is no earlier than N+3 (pop, fetch, data).
- frame_avail is 1 while the queue is not empty or the FSM is not in R_IDLE.
- A frame never becomes visible before commit. Uncommitted bytes never reach the output.
- Free space is reclaimed only as rd_ptr advances. The writer must never overwrite unread committed bytes.

Optional Feature:
- Macro: TCP_RX_LEN_CHECK_EN.
- Defined: at frame_done, a frame whose wcnt!=frame_len is dropped (rollback plus drop_cnt++), even if otherwise valid.
- Undefined: frame_len is ignored, and wcnt alone sets the committed length.

Test Plan:
- Write 5 bytes 0x11..0x15 with frame_done on the 5th byte's cycle, out_ready=1 -> stream 0x11..0x15 at 1 byte/cycle, out_last only on 0x15, drop_cnt=0.
- Same frame with out_ready toggling 1,0 each cycle -> each byte held stable while not ready; no loss or duplication.
- Write 3 bytes, then no frame_done for 64 cycles -> nothing output, drop_cnt=1. Then a following 2-byte frame 0xA0,0xA1 is committed -> stream outputs exactly 0xA0,0xA1.
- ADDR_W=4: a 20-byte frame with out_ready=0 -> overflow, dropped on frame_done, drop_cnt=1. A subsequent 4-byte frame outputs correctly across pointer wrap.
- Commit 9 one-byte frames with out_ready=0 (LQ_AW=3) -> the 9th is dropped and drop_cnt=1. After out_ready=1, exactly 8 bytes emerge, each with out_last=1.
- With TCP_RX_LEN_CHECK_EN: 4 bytes with frame_len=6 -> dropped, drop_cnt=1. 6 bytes with frame_len=6 -> delivered.

Source files
------------

// File: rtl/tcp_rx_payload_buffer.sv
// Payload buffer behind the TCP/IP receive parser: tentative capture, commit/rollback, byte stream out.
// Optional build macro TCP_RX_LEN_CHECK_EN drops frames whose byte count differs from frame_len.
module tcp_rx_payload_buffer #(
    parameter int ADDR_W  = 11,
    parameter int LQ_AW   = 3,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  din,
    input  logic        din_valid,
    input  logic        frame_done,
    input  logic [15:0] frame_len,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        frame_avail,
    output logic [7:0]  drop_cnt
);

    localparam int DEPTH    = 1 << ADDR_W;
    localparam int LQ_DEPTH = 1 << LQ_AW;

    localparam logic [ADDR_W-1:0] PONE    = 1;
    localparam logic [LQ_AW:0]    QONE    = 1;
    localparam logic [15:0]       TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [LQ_AW+1:0]  LQ_MAX  = (LQ_AW + 2)'(LQ_DEPTH);

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_SEND
    } rstate_t;

    logic [7:0]  mem [DEPTH];
    logic [15:0] lq  [LQ_DEPTH];

    logic [ADDR_W-1:0] wr_ptr, cm_ptr, rd_ptr, wr_ptr_n;
    logic [15:0]       wcnt, wcnt_n, timer, rlen;
    logic              ovf, ovf_n;
    logic [LQ_AW:0]    lq_wp, lq_rp, lq_cnt;
    logic [LQ_AW+1:0]  outstanding;
    logic              lq_empty, lq_full, busy;

    logic wr_ok, len_bad, drop, push, drop_inc, idle, tmo, bump;

    rstate_t state, state_n;
    logic    pop, fetch, xfer;

    assign busy        = (state != R_IDLE);
    assign lq_empty    = (lq_wp == lq_rp);
    assign lq_cnt      = lq_wp - lq_rp;
    // The frame held by the read FSM still occupies a slot of the budget.
    assign outstanding = {1'b0, lq_cnt} + {{(LQ_AW + 1){1'b0}}, busy};
    assign lq_full     = (outstanding >= LQ_MAX);
    assign frame_avail = !lq_empty || busy;

`ifdef TCP_RX_LEN_CHECK_EN
    assign len_bad = (wcnt_n != frame_len);
`else
    logic unused_len;
    assign unused_len = ^frame_len;
    assign len_bad    = 1'b0;
`endif

    always_comb begin
        wr_ok    = din_valid && ((wr_ptr + PONE) != rd_ptr);
        wr_ptr_n = wr_ok ? (wr_ptr + PONE) : wr_ptr;
        wcnt_n   = wcnt + {15'd0, wr_ok};
        ovf_n    = ovf | (din_valid & ~wr_ok);
        drop     = frame_done &&
                   ((wcnt_n == 16'd0) || ovf_n || lq_full || len_bad);
        push     = frame_done && !drop;
        drop_inc = drop && ((wcnt_n != 16'd0) || ovf_n || len_bad);
        idle     = !din_valid && !frame_done && (wcnt != 16'd0);
        tmo      = idle && (timer == TO_LAST);
        bump     = (frame_done ? drop_inc : tmo) && (drop_cnt != 8'hFF);
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
        if (push) begin
            lq[lq_wp[LQ_AW-1:0]] <= wcnt_n;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr   <= '0;
            cm_ptr   <= '0;
            wcnt     <= '0;
            ovf      <= 1'b0;
            timer    <= '0;
            lq_wp    <= '0;
            drop_cnt <= '0;
        end else begin
            if (frame_done) begin
                wcnt  <= '0;
                ovf   <= 1'b0;
                timer <= '0;
                if (drop) begin
                    wr_ptr <= cm_ptr;
                end else begin
                    wr_ptr <= wr_ptr_n;
                    cm_ptr <= wr_ptr_n;
                    lq_wp  <= lq_wp + QONE;
                end
            end else if (tmo) begin
                wr_ptr <= cm_ptr;
                wcnt   <= '0;
                ovf    <= 1'b0;
                timer  <= '0;
            end else begin
                wr_ptr <= wr_ptr_n;
                wcnt   <= wcnt_n;
                ovf    <= ovf_n;
                timer  <= idle ? (timer + 16'd1) : 16'd0;
            end
            if (bump) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= R_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        fetch   = 1'b0;
        xfer    = 1'b0;
        unique case (state)
            R_IDLE: begin
                if (!lq_empty) begin
                    pop     = 1'b1;
                    state_n = R_FETCH;
                end
            end
            R_FETCH: begin
                fetch   = 1'b1;
                state_n = R_SEND;
            end
            R_SEND: begin
                if (out_ready) begin
                    xfer = 1'b1;
                    if (rlen == 16'd1) begin
                        state_n = R_IDLE;
                    end
                end
            end
            default: state_n = R_IDLE;
        endcase
    end

    // Next byte is prefetched on every non-final transfer, so a ready
    // consumer sees one byte per cycle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rd_ptr    <= '0;
            rlen      <= '0;
            lq_rp     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (pop) begin
                rlen  <= lq[lq_rp[LQ_AW-1:0]];
                lq_rp <= lq_rp + QONE;
            end
            if (fetch) begin
                out_valid <= 1'b1;
                out_data  <= mem[rd_ptr];
                out_last  <= (rlen == 16'd1);
            end
            if (xfer) begin
                rd_ptr <= rd_ptr + PONE;
                rlen   <= rlen - 16'd1;
                if (rlen == 16'd1) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    out_data <= mem[rd_ptr + PONE];
                    out_last <= (rlen == 16'd2);
                end
            end
        end
    end

endmodule
